// File: rtl/uart_frame_parser.sv
`timescale 1ns/1ps
// uart_frame_parser: delineates SOF/CMD/ADDR/DATA/CRC command frames from the UART RX FIFO,
// checks them and holds one decoded frame until the bridge consumes it.
module uart_frame_parser #(
    parameter int unsigned BYTE_TIMEOUT_CYCLES = 125_000,
    parameter logic [7:0]  SOF_BYTE            = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        parser_frame_valid,
    output logic        parser_frame_error,
    output logic [7:0]  parser_error_code,
    input  logic        parser_frame_consumed,
    output logic [7:0]  frame_cmd,
    output logic [31:0] frame_addr,
    output logic [6:0]  frame_data_bytes,
    input  logic [5:0]  data_rd_idx,
    output logic [7:0]  data_rd_byte
);
    if (BYTE_TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $fatal(1, "uart_frame_parser: BYTE_TIMEOUT_CYCLES must be non-zero");
    end

    localparam int unsigned     TmoW    = $clog2(BYTE_TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(BYTE_TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ErrOk      = 8'h00;
    localparam logic [7:0] ErrCrc     = 8'h01;
    localparam logic [7:0] ErrCmdInv  = 8'h02;
    localparam logic [7:0] ErrAlign   = 8'h03;
    localparam logic [7:0] ErrTimeout = 8'h04;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StCrc, StHold} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q;
    logic [31:0]     addr_q;
    logic [6:0]      count_q;
    logic [1:0]      addr_cnt_q;
    logic [6:0]      data_idx_q;
    logic [7:0]      crc_q;
    logic [7:0]      code_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      buffer [64];

    logic accept, in_frame, timeout, sof_seen;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Reads and reserved SIZE carry no payload.
    function automatic logic [6:0] payload_count(input logic [7:0] cmd);
        logic [6:0] beats;
        beats = {3'b000, cmd[3:0]} + 7'd1;
        if (cmd[7] || cmd[5:4] == 2'b11) begin
            return 7'd0;
        end
        return beats << cmd[5:4];
    endfunction

    assign rx_ready = (state_q != StHold);
    assign accept   = rx_valid && rx_ready;
    assign sof_seen = accept && (rx_data == SOF_BYTE);
    assign in_frame = (state_q == StCmd) || (state_q == StAddr) ||
                      (state_q == StData) || (state_q == StCrc);
    // Fires on the idle cycle that brings the counter to BYTE_TIMEOUT_CYCLES.
    assign timeout  = in_frame && !accept && (tmo_q == TmoLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (sof_seen) state_d = StCmd;
            StCmd:  if (accept) state_d = StAddr;
            StAddr: if (accept && addr_cnt_q == 2'd3) begin
                state_d = (count_q != 7'd0) ? StData : StCrc;
            end
            StData: if (accept && data_idx_q == count_q - 7'd1) state_d = StCrc;
            StCrc:  if (accept) state_d = StHold;
            StHold: if (parser_frame_consumed) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StHold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= 8'h00;
            addr_q     <= 32'h0;
            count_q    <= 7'd0;
            addr_cnt_q <= 2'd0;
            data_idx_q <= 7'd0;
            crc_q      <= 8'h00;
            code_q     <= ErrOk;
            tmo_q      <= '0;
        end else begin
            tmo_q <= (in_frame && !accept) ? tmo_q + 1'b1 : '0;
            unique case (state_q)
                StIdle: if (sof_seen) begin
                    cmd_q      <= 8'h00;
                    addr_q     <= 32'h0;
                    count_q    <= 7'd0;
                    addr_cnt_q <= 2'd0;
                    data_idx_q <= 7'd0;
                    crc_q      <= 8'h00;
                    code_q     <= ErrOk;
                end
                StCmd: if (accept) begin
                    cmd_q   <= rx_data;
                    count_q <= payload_count(rx_data);
                    crc_q   <= crc8_next(crc_q, rx_data);
                end
                StAddr: if (accept) begin
                    addr_q[{addr_cnt_q, 3'b000} +: 8] <= rx_data;
                    addr_cnt_q <= addr_cnt_q + 2'd1;
                    crc_q      <= crc8_next(crc_q, rx_data);
                end
                StData: if (accept) begin
                    data_idx_q <= data_idx_q + 7'd1;
                    crc_q      <= crc8_next(crc_q, rx_data);
                end
                StCrc: if (accept) begin
                    if (rx_data != crc_q) begin
                        code_q <= ErrCrc;
                    end else if (cmd_q[5:4] == 2'b11) begin
                        code_q <= ErrCmdInv;
                    end else if ((cmd_q[5:4] == 2'b01 && addr_q[0]) ||
                                 (cmd_q[5:4] == 2'b10 && addr_q[1:0] != 2'b00)) begin
                        code_q <= ErrAlign;
                    end else begin
                        code_q <= ErrOk;
                    end
                end
                StHold: if (parser_frame_consumed) code_q <= ErrOk;
                default: ;
            endcase
            if (timeout) begin
                code_q <= ErrTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StData && accept) begin
            buffer[data_idx_q[5:0]] <= rx_data;
        end
    end

    assign parser_frame_valid = (state_q == StHold);
    assign parser_frame_error = (code_q != ErrOk);
    assign parser_error_code  = code_q;
    assign frame_cmd          = cmd_q;
    assign frame_addr         = addr_q;
    assign frame_data_bytes   = count_q;
    assign data_rd_byte       = buffer[data_rd_idx];

endmodule

// File: tb/tb_uart_frame_parser.sv
`timescale 1ns/1ps
// Bench for uart_frame_parser: a frame-level reference model compared every cycle, plus
// directed frames with hand-computed literal expectations.
module tb_uart_frame_parser;
    localparam int unsigned T = 100;

    typedef logic [7:0] byteq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parser_frame_valid;
    logic        parser_frame_error;
    logic [7:0]  parser_error_code;
    logic        parser_frame_consumed;
    logic [7:0]  frame_cmd;
    logic [31:0] frame_addr;
    logic [6:0]  frame_data_bytes;
    logic [5:0]  data_rd_idx;
    logic [7:0]  data_rd_byte;

    int n_cmp = 0;
    int n_bad = 0;

    uart_frame_parser #(
        .BYTE_TIMEOUT_CYCLES(T),
        .SOF_BYTE           (8'hA5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .rx_ready             (rx_ready),
        .parser_frame_valid   (parser_frame_valid),
        .parser_frame_error   (parser_frame_error),
        .parser_error_code    (parser_error_code),
        .parser_frame_consumed(parser_frame_consumed),
        .frame_cmd            (frame_cmd),
        .frame_addr           (frame_addr),
        .frame_data_bytes     (frame_data_bytes),
        .data_rd_idx          (data_rd_idx),
        .data_rd_byte         (data_rd_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int payload(input logic [7:0] c);
        int bpb;
        if (c[7]) return 0;
        case (c[5:4])
            2'b00:   bpb = 1;
            2'b01:   bpb = 2;
            2'b10:   bpb = 4;
            default: return 0;
        endcase
        return (int'(c[3:0]) + 1) * bpb;
    endfunction

    function automatic logic [7:0] crc8(input byteq_t q, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ q[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Frame builder: SOF, cmd, little-endian addr, data, CRC (optionally corrupted by xor).
    function automatic byteq_t mk_frame(input logic [7:0] cmd, input logic [31:0] addr,
                                        input byteq_t data, input logic [7:0] crc_xor);
        byteq_t body;
        byteq_t f;
        body.push_back(cmd);
        for (int k = 0; k < 4; k++) body.push_back(addr[8*k +: 8]);
        foreach (data[i]) body.push_back(data[i]);
        f.push_back(8'hA5);
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(crc8(body, body.size()) ^ crc_xor);
        return f;
    endfunction

    // ---------------- reference model ----------------
    logic        m_hold = 1'b0;
    logic        m_in_frame = 1'b0;
    byteq_t      m_q;
    int          m_idle = 0;
    logic [7:0]  exp_code = 8'h00;
    logic [7:0]  exp_cmd = 8'h00;
    logic [31:0] exp_addr = 32'h0;
    int          exp_nbytes = 0;
    int          exp_rcvd = 0;
    logic [7:0]  exp_data [64];

    task automatic finish_frame(input bit timed_out);
        int n;
        int sz;
        n = m_q.size();
        m_hold = 1'b1;
        exp_cmd = (n > 0) ? m_q[0] : 8'h00;
        exp_addr = 32'h0;
        for (int k = 0; k < 4; k++) if (n > k + 1) exp_addr[8*k +: 8] = m_q[k+1];
        exp_nbytes = (n > 0) ? payload(m_q[0]) : 0;
        exp_rcvd = 0;
        for (int k = 0; k < exp_nbytes; k++) begin
            if (n > 5 + k) begin
                exp_data[k] = m_q[5+k];
                exp_rcvd = k + 1;
            end
        end
        sz = int'(exp_cmd[5:4]);
        if (timed_out) exp_code = 8'h04;
        else if (crc8(m_q, n - 1) != m_q[n-1]) exp_code = 8'h01;
        else if (sz == 3) exp_code = 8'h02;
        else if ((sz == 1 && exp_addr[0]) || (sz == 2 && exp_addr[1:0] != 2'b00)) exp_code = 8'h03;
        else exp_code = 8'h00;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hold = 1'b0;
                m_in_frame = 1'b0;
                m_q.delete();
                m_idle = 0;
                exp_code = 8'h00;
            end else if (m_hold) begin
                if (parser_frame_consumed) begin
                    m_hold = 1'b0;
                    m_in_frame = 1'b0;
                    exp_code = 8'h00;
                end
            end else if (rx_valid) begin
                if (!m_in_frame) begin
                    if (rx_data == 8'hA5) begin
                        m_in_frame = 1'b1;
                        m_q.delete();
                        m_idle = 0;
                    end
                end else begin
                    m_q.push_back(rx_data);
                    m_idle = 0;
                    if (m_q.size() == 6 + payload(m_q[0])) finish_frame(1'b0);
                end
            end else if (m_in_frame) begin
                m_idle++;
                if (m_idle == int'(T)) finish_frame(1'b1);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("rx_ready", {31'b0, rx_ready}, {31'b0, !m_hold});
            chk("valid", {31'b0, parser_frame_valid}, {31'b0, m_hold});
            if (m_hold) begin
                chk("error", {31'b0, parser_frame_error}, {31'b0, exp_code != 8'h00});
                chk("code", {24'b0, parser_error_code}, {24'b0, exp_code});
                chk("cmd", {24'b0, frame_cmd}, {24'b0, exp_cmd});
                chk("addr", frame_addr, exp_addr);
                chk("data_bytes", {25'b0, frame_data_bytes}, exp_nbytes);
                if (int'(data_rd_idx) < exp_rcvd)
                    chk("data", {24'b0, data_rd_byte}, {24'b0, exp_data[data_rd_idx]});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_frame(input byteq_t f);
        foreach (f[i]) begin
            rx_valid = 1'b1;
            rx_data  = f[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic consume();
        parser_frame_consumed = 1'b1;
        @(posedge clk); #1;
        parser_frame_consumed = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int k = 0; k < n; k++) begin
            data_rd_idx = 6'(k);
            @(posedge clk); #1;
        end
        data_rd_idx = 6'd0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, {31'b0, rx_ready}, 32'd1);
        chk({tag, "_valid"}, {31'b0, parser_frame_valid}, 32'd0);
        chk({tag, "_error"}, {31'b0, parser_frame_error}, 32'd0);
        chk({tag, "_code"}, {24'b0, parser_error_code}, 32'd0);
        chk({tag, "_cmd"}, {24'b0, frame_cmd}, 32'd0);
        chk({tag, "_addr"}, frame_addr, 32'd0);
        chk({tag, "_nbytes"}, {25'b0, frame_data_bytes}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        byteq_t f;
        byteq_t d;
        byteq_t pin;
        int cycles;

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        parser_frame_consumed = 1'b0;
        data_rd_idx = 6'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_values("reset");

        pin = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h00};
        chk("model_crc_pin", {24'b0, crc8(pin, 5)}, 32'h51);
        chk("model_payload_pin", payload(8'h2F), 32'd64);

        // Read frame with literal CRC.
        f = '{8'hA5, 8'hA0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h51};
        send_frame(f);
        chk("rd_valid", {31'b0, parser_frame_valid}, 32'd1);
        chk("rd_error", {31'b0, parser_frame_error}, 32'd0);
        chk("rd_code", {24'b0, parser_error_code}, 32'h00);
        chk("rd_cmd", {24'b0, frame_cmd}, 32'hA0);
        chk("rd_addr", frame_addr, 32'h0000_1000);
        chk("rd_nbytes", {25'b0, frame_data_bytes}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rd_hold_ready", {31'b0, rx_ready}, 32'd0);
        consume();
        chk("rd_consumed_valid", {31'b0, parser_frame_valid}, 32'd0);
        chk("rd_consumed_ready", {31'b0, rx_ready}, 32'd1);

        // Same frame, bad CRC.
        f = '{8'hA5, 8'hA0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h52};
        send_frame(f);
        chk("badcrc_error", {31'b0, parser_frame_error}, 32'd1);
        chk("badcrc_code", {24'b0, parser_error_code}, 32'h01);
        consume();

        // Garbage then a 4-byte write.
        f = '{8'h00, 8'h13};
        send_frame(f);
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(mk_frame(8'h20, 32'h0000_2000, d, 8'h00));
        chk("wr_code", {24'b0, parser_error_code}, 32'h00);
        chk("wr_nbytes", {25'b0, frame_data_bytes}, 32'd4);
        chk("wr_addr", frame_addr, 32'h0000_2000);
        data_rd_idx = 6'd0;
        #1 chk("wr_byte0", {24'b0, data_rd_byte}, 32'hDE);
        data_rd_idx = 6'd3;
        #1 chk("wr_byte3", {24'b0, data_rd_byte}, 32'hEF);
        sweep(4);
        consume();

        // 2-byte beats, odd address.
        d = '{8'h11, 8'h22};
        send_frame(mk_frame(8'h10, 32'h0000_0001, d, 8'h00));
        chk("align2_code", {24'b0, parser_error_code}, 32'h03);
        chk("align2_nbytes", {25'b0, frame_data_bytes}, 32'd2);
        consume();

        // Reserved SIZE on a read.
        d = {};
        send_frame(mk_frame(8'hB0, 32'h0000_0000, d, 8'h00));
        chk("cmdinv_code", {24'b0, parser_error_code}, 32'h02);
        chk("cmdinv_nbytes", {25'b0, frame_data_bytes}, 32'd0);
        consume();

        // Reserved SIZE, misaligned, bad CRC: CRC wins.
        send_frame(mk_frame(8'h30, 32'h0000_0001, d, 8'h5A));
        chk("prio_code", {24'b0, parser_error_code}, 32'h01);
        consume();

        // 4-byte beats x2, addr[1] set; data sweep over 8 bytes.
        d = '{8'h01, 8'h02, 8'hA5, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(mk_frame(8'h21, 32'h1234_5602, d, 8'h00));
        chk("align4_code", {24'b0, parser_error_code}, 32'h03);
        chk("align4_nbytes", {25'b0, frame_data_bytes}, 32'd8);
        sweep(8);
        consume();

        // Timeout after SOF, CMD, ADDR0.
        f = '{8'hA5, 8'hA0, 8'h00};
        send_frame(f);
        cycles = 1;
        while (!parser_frame_valid && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("tmo_latency", cycles, 32'd101);
        chk("tmo_code", {24'b0, parser_error_code}, 32'h04);
        chk("tmo_cmd", {24'b0, frame_cmd}, 32'hA0);

        // Consume, then SOF on the very next cycle.
        consume();
        chk("b2b_ready", {31'b0, rx_ready}, 32'd1);
        d = '{8'h5A, 8'hC3};
        send_frame(mk_frame(8'h01, 32'h0000_0040, d, 8'h00));
        chk("b2b_valid", {31'b0, parser_frame_valid}, 32'd1);
        chk("b2b_code", {24'b0, parser_error_code}, 32'h00);
        sweep(2);
        consume();

        // Consume pulse in IDLE is ignored.
        consume();
        chk("idle_consume_ready", {31'b0, rx_ready}, 32'd1);
        chk("idle_consume_valid", {31'b0, parser_frame_valid}, 32'd0);

        // Reset mid-DATA.
        f = '{8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'h98, 8'h97};
        send_frame(f);
        rst = 1'b1;
        #1 chk_reset_values("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_values("post_rst");
        d = {};
        send_frame(mk_frame(8'h80, 32'hCAFE_0000, d, 8'h00));
        chk("post_rst_code", {24'b0, parser_error_code}, 32'h00);
        chk("post_rst_addr", frame_addr, 32'hCAFE_0000);
        consume();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser sitting directly upstream of the UART-AXI4 bridge main FSM. It consumes bytes from the UART RX FIFO, delineates command frames, checks them (CRC-8, command legality, address alignment, inter-byte timeout) and holds one decoded frame until the bridge consumes it. Its outputs drive the bridge's `parser_frame_valid` / `parser_frame_error` / `parser_frame_consumed` handshake.

## Interface
- `BYTE_TIMEOUT_CYCLES`, 125_000: idle cycles allowed between accepted bytes inside a frame. Must be non-zero; a zero value is a `$fatal` at elaboration.
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `rx_data` in 8: byte from the RX FIFO.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: parser accepts the byte. A byte transfers when `rx_valid && rx_ready`.
- `parser_frame_valid` out 1: a frame is held for the bridge.
- `parser_frame_error` out 1: the held frame is erroneous. Qualified by `parser_frame_valid`.
- `parser_error_code` out 8: 0x00 OK, 0x01 CRC, 0x02 CMD_INV, 0x03 ADDR_ALIGN, 0x04 TIMEOUT.
- `parser_frame_consumed` in 1: single-cycle pulse from the bridge releasing the frame.
- `frame_cmd` out 8: CMD byte.
- `frame_addr` out 32: address, little-endian over the wire.
- `frame_data_bytes` out 7: number of payload bytes, 0..64.
- `data_rd_idx` in 6: payload buffer read index.
- `data_rd_byte` out 8: `buffer[data_rd_idx]`, combinational read.

## Operation
- CMD byte fields:
  - bit7 RW (1 = read).
  - bit6 INC.
  - bits5:4 SIZE: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 reserved.
  - bits3:0 LEN-1, giving beats 1..16.
- Write frame on the wire: SOF, CMD, ADDR0..ADDR3, DATA (LEN × bytes-per-beat), CRC.
- Read frame on the wire: SOF, CMD, ADDR0..ADDR3, CRC.
- CRC-8:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over CMD through the last data byte; SOF is excluded.
- FSM states: IDLE, CMD, ADDR, DATA, CRC, HOLD.
  - IDLE: an accepted byte equal to SOF_BYTE moves to CMD. Any other byte is discarded silently.
  - CMD: latch `frame_cmd` and compute the payload count.
    - Read, or reserved SIZE: count = 0.
    - Otherwise: count = LEN × bpb.
    - Go to ADDR.
  - ADDR: 4 bytes, with a 2-bit counter. Then go to DATA if count != 0, else go to CRC.
  - DATA: store bytes at index 0..count-1; go to CRC after the last byte. A byte equal to SOF_BYTE inside a frame is plain data; there is no resync.
  - CRC: compare the received byte with the running CRC, resolve the error code, go to HOLD.
  - HOLD: `parser_frame_valid` = 1 and `rx_ready` = 0. On `parser_frame_consumed`, go to IDLE.
- Error priority when several apply: CRC (0x01) > CMD_INV (0x02, SIZE = 11) > ADDR_ALIGN (0x03).
  - Alignment rule: 2 B needs addr[0] = 0; 4 B needs addr[1:0] = 0.
  - `parser_frame_error` = (`parser_error_code` != 0).
- Timeout:
  - Counter width is `$clog2(BYTE_TIMEOUT_CYCLES+1)`. It clears on every accepted byte and in IDLE/HOLD, and increments each other cycle in CMD..CRC.
  - When the counter reaches BYTE_TIMEOUT_CYCLES, go to HOLD with code 0x04.
  - `frame_cmd` and `frame_addr` keep whatever was received; bytes not yet received read 0.
- `frame_*` fields clear to 0 on leaving IDLE for CMD. They stay stable throughout HOLD.
- `parser_frame_consumed` outside HOLD is ignored.

## Timing
- Reset values: state IDLE, `rx_ready` = 1, `parser_frame_valid` = 0, `parser_frame_error` = 0, `parser_error_code` = 0, `frame_cmd` = 0, `frame_addr` = 0, `frame_data_bytes` = 0, counters = 0. Buffer contents are don't-care.
- `rx_ready` is high in every state except HOLD.
- At most one byte is accepted per cycle; there are no bubbles needed between bytes.
- CRC byte accepted at cycle N: `parser_frame_valid`, `parser_frame_error` and code are high/valid at N+1, all registered.
- Timeout: the last byte is accepted at cycle N; `parser_frame_valid` rises at N + BYTE_TIMEOUT_CYCLES + 1.
- Consume pulse at cycle M: `parser_frame_valid` = 0 and `rx_ready` = 1 at M+1. A byte presented at M+1 is accepted in IDLE.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.

## Test plan
- Read frame A5 A0 00 10 00 00 51 → one cycle after the CRC byte: valid = 1, error = 0, code 0x00, cmd 0xA0, addr 0x00001000, data_bytes 0; `rx_ready` = 0 until consumed.
- Same frame with CRC byte 0x52 → valid = 1, error = 1, code 0x01.
- Write frame CMD 0x20, addr 0x00002000, data DE AD BE EF, correct CRC → data_bytes 4; `data_rd_byte` = 0xDE at idx 0 and 0xEF at idx 3. Preceding garbage bytes 0x00 0x13 are dropped silently.
- CMD 0x10 (2 B), addr 0x00000001, correct CRC → code 0x03. CMD 0xB0 (reserved SIZE), correct CRC → code 0x02, data_bytes 0.
- BYTE_TIMEOUT_CYCLES = 100, send A5 A0 00 then stall → valid rises exactly 101 cycles after the last byte, code 0x04, cmd 0xA0.
- Consume-then-back-to-back: pulse consumed and drive the next SOF on the following cycle → the byte is accepted; a consume pulse in IDLE has no effect; reset during DATA → all outputs return to reset values.
